// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences EX/MEM loads and stores onto a split-handshake
// data bus (address phase, then data/response phase). It builds byte strobes
// and replicated write data, holds the pipeline via stallreq, and returns
// aligned, extended load data. A watchdog ends stuck accesses with bus_err.
//
// Build option: MEM_ACCESS_ALIGN_CHK_EN
//   defined   - misaligned half/word requests raise misalign and are dropped
//   undefined - misalign is tied low; half/word addresses are force-aligned
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a request; accepts an aligned req_valid
// S_ADDR | dbus_req held high until dbus_addr_ok
// S_DATA | address accepted, waiting for dbus_data_ok
// S_DONE | one-cycle response (resp_valid, optional bus_err)

module mem_access_ctrl #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stallreq,
   output logic        misalign,
   output logic        dbus_req,
   output logic        dbus_wr,
   output logic [3:0]  dbus_wstrb,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_addr_ok,
   input  logic        dbus_data_ok,
   input  logic [31:0] dbus_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [15:0] WDOG_LAST = 16'(WAIT_MAX - 1);

   state_t      state_q, state_d;
   logic [15:0] wdog_q, wdog_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic [1:0]  alo_q, alo_d;
   logic        dbus_req_q, dbus_req_d;
   logic        dbus_wr_q, dbus_wr_d;
   logic [3:0]  dbus_wstrb_q, dbus_wstrb_d;
   logic [31:0] dbus_addr_q, dbus_addr_d;
   logic [31:0] dbus_wdata_q, dbus_wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        bus_err_q, bus_err_d;

   logic        is_byte, is_half, is_word;
   logic [1:0]  addr_lo;
   logic [3:0]  req_strb;
   logic [31:0] req_wrep;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   assign is_byte = (req_size == 2'b00);
   assign is_half = (req_size == 2'b01);
   assign is_word = req_size[1];

`ifdef MEM_ACCESS_ALIGN_CHK_EN
   assign misalign = req_valid &
                     ((is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00)));
   assign addr_lo  = req_addr[1:0];
`else
   assign misalign = 1'b0;
   // Without the checker, low address bits that a half/word cannot use are dropped.
   always_comb begin
      addr_lo = req_addr[1:0];
      if (is_word)
         addr_lo = 2'b00;
      else if (is_half)
         addr_lo = {req_addr[1], 1'b0};
   end
`endif

   // Strobes and lane-replicated write data for the incoming request.
   always_comb begin
      req_strb = 4'b1111;
      req_wrep = req_wdata;
      if (is_byte) begin
         req_strb = 4'b0001 << addr_lo;
         req_wrep = {4{req_wdata[7:0]}};
      end else if (is_half) begin
         req_strb = 4'b0011 << {addr_lo[1], 1'b0};
         req_wrep = {2{req_wdata[15:0]}};
      end
   end

   assign byte_sel = dbus_rdata[{alo_q, 3'b000} +: 8];
   assign half_sel = dbus_rdata[{alo_q[1], 4'b0000} +: 16];

   // Load alignment and sign/zero extension of the returned word.
   always_comb begin
      load_data = dbus_rdata;
      if (size_q == 2'b00)
         load_data = {{24{sign_q & byte_sel[7]}}, byte_sel};
      else if (size_q == 2'b01)
         load_data = {{16{sign_q & half_sel[15]}}, half_sel};
   end

   assign stallreq = ((state_q == S_IDLE) & req_valid & ~misalign) |
                     (state_q == S_ADDR) | (state_q == S_DATA);

   // Next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      wdog_d       = wdog_q;
      size_d       = size_q;
      sign_d       = sign_q;
      alo_d        = alo_q;
      dbus_req_d   = dbus_req_q;
      dbus_wr_d    = dbus_wr_q;
      dbus_wstrb_d = dbus_wstrb_q;
      dbus_addr_d  = dbus_addr_q;
      dbus_wdata_d = dbus_wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = 32'h0;
      bus_err_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid && !misalign) begin
               size_d       = req_size;
               sign_d       = req_sign;
               alo_d        = addr_lo;
               dbus_req_d   = 1'b1;
               dbus_wr_d    = req_we;
               dbus_wstrb_d = req_strb;
               dbus_addr_d  = {req_addr[31:2], 2'b00};
               dbus_wdata_d = req_wrep;
               wdog_d       = 16'h0;
               state_d      = S_ADDR;
            end
         end
         S_ADDR: begin
            wdog_d = wdog_q + 16'd1;
            if (dbus_addr_ok && dbus_data_ok) begin
               dbus_req_d   = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = dbus_wr_q ? 32'h0 : load_data;
               state_d      = S_DONE;
            end else if (wdog_q == WDOG_LAST) begin
               dbus_req_d   = 1'b0;
               resp_valid_d = 1'b1;
               bus_err_d    = 1'b1;
               state_d      = S_DONE;
            end else if (dbus_addr_ok) begin
               dbus_req_d = 1'b0;
               state_d    = S_DATA;
            end
         end
         S_DATA: begin
            wdog_d = wdog_q + 16'd1;
            if (dbus_data_ok) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = dbus_wr_q ? 32'h0 : load_data;
               state_d      = S_DONE;
            end else if (wdog_q == WDOG_LAST) begin
               resp_valid_d = 1'b1;
               bus_err_d    = 1'b1;
               state_d      = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, watchdog and output registers; reset abandons any bus access.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         wdog_q       <= 16'h0;
         size_q       <= 2'b00;
         sign_q       <= 1'b0;
         alo_q        <= 2'b00;
         dbus_req_q   <= 1'b0;
         dbus_wr_q    <= 1'b0;
         dbus_wstrb_q <= 4'h0;
         dbus_addr_q  <= 32'h0;
         dbus_wdata_q <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wdog_q       <= wdog_d;
         size_q       <= size_d;
         sign_q       <= sign_d;
         alo_q        <= alo_d;
         dbus_req_q   <= dbus_req_d;
         dbus_wr_q    <= dbus_wr_d;
         dbus_wstrb_q <= dbus_wstrb_d;
         dbus_addr_q  <= dbus_addr_d;
         dbus_wdata_q <= dbus_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign dbus_req   = dbus_req_q;
   assign dbus_wr    = dbus_wr_q;
   assign dbus_wstrb = dbus_wstrb_q;
   assign dbus_addr  = dbus_addr_q;
   assign dbus_wdata = dbus_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (WAIT_MAX = 8). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid, req_we, req_sign;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        stallreq, misalign;
   logic        dbus_req, dbus_wr;
   logic [3:0]  dbus_wstrb;
   logic [31:0] dbus_addr, dbus_wdata;
   logic        dbus_addr_ok, dbus_data_ok;
   logic [31:0] dbus_rdata;
   logic        resp_valid, bus_err;
   logic [31:0] resp_rdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_MAX(8)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
      .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
      .stallreq(stallreq), .misalign(misalign),
      .dbus_req(dbus_req), .dbus_wr(dbus_wr), .dbus_wstrb(dbus_wstrb),
      .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
      .dbus_addr_ok(dbus_addr_ok), .dbus_data_ok(dbus_data_ok),
      .dbus_rdata(dbus_rdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .bus_err(bus_err)
   );

   // a: bus cycle index carrying addr_ok; d: further cycles until data_ok
   // bus: hand-computed number of cycles spent in ADDR+DATA
   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          a;
      int          d;
      int          bus;
      logic [3:0]  strb;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic        err;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int id, input vec_t v);
      string t;
      t = $sformatf("v%0d", id);
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = v.we;
      req_size     = v.size;
      req_sign     = v.sign;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      dbus_addr_ok = 1'b0;
      dbus_data_ok = 1'b0;
      dbus_rdata   = v.rdata;
      #1;
      chk({t, " stall_c0"}, {31'h0, stallreq}, 32'h1);
      chk({t, " misalign"}, {31'h0, misalign}, 32'h0);
      for (int k = 0; k < v.bus; k++) begin
         @(negedge clk);
         chk($sformatf("%s stall_b%0d", t, k), {31'h0, stallreq}, 32'h1);
         chk($sformatf("%s resp_valid_b%0d", t, k), {31'h0, resp_valid}, 32'h0);
         chk($sformatf("%s dbus_req_b%0d", t, k), {31'h0, dbus_req}, {31'h0, (k <= v.a)});
         chk($sformatf("%s dbus_wr_b%0d", t, k), {31'h0, dbus_wr}, {31'h0, v.we});
         chk($sformatf("%s wstrb_b%0d", t, k), {28'h0, dbus_wstrb}, {28'h0, v.strb});
         chk($sformatf("%s dbus_addr_b%0d", t, k), dbus_addr, v.exp_addr);
         chk($sformatf("%s dbus_wdata_b%0d", t, k), dbus_wdata, v.exp_wdata);
         dbus_addr_ok = (k == v.a);
         dbus_data_ok = (k == v.a + v.d);
      end
      @(negedge clk);
      chk({t, " resp_valid_done"}, {31'h0, resp_valid}, 32'h1);
      chk({t, " bus_err_done"}, {31'h0, bus_err}, {31'h0, v.err});
      chk({t, " resp_rdata"}, resp_rdata, v.exp_rdata);
      chk({t, " stall_done"}, {31'h0, stallreq}, 32'h0);
      chk({t, " dbus_req_done"}, {31'h0, dbus_req}, 32'h0);
      req_valid    = 1'b0;
      dbus_addr_ok = 1'b0;
      dbus_data_ok = 1'b0;
      @(negedge clk);
      chk({t, " resp_valid_after"}, {31'h0, resp_valid}, 32'h0);
      chk({t, " bus_err_after"}, {31'h0, bus_err}, 32'h0);
      chk({t, " stall_after"}, {31'h0, stallreq}, 32'h0);
   endtask

   initial begin
      vec_t v;
      //         we    size   sign  addr          wdata         rdata         a    d    bus strb     exp_addr      exp_wdata     exp_rdata     err
      vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,        32'hDEADBEEF, 0,   0,   1, 4'b1111, 32'h0000_1000, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h80FFFFFF, 0,   0,   1, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFFFF80, 1'b0};
      vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80FFFFFF, 0,   0,   1, 4'b1000, 32'h0000_1000, 32'h0,        32'h00000080, 1'b0};
      vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234ABCD, 32'hFFFFFFFF, 3,   2,   6, 4'b1100, 32'h0000_2000, 32'hABCDABCD, 32'h0,        1'b0};
      vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0,        32'hDEADBEEF, 100, 0,   8, 4'b1111, 32'h0000_3000, 32'h0,        32'h0,        1'b1};
      vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'h0,        32'h80017FFF, 1,   1,   3, 4'b1100, 32'h0000_4000, 32'h0,        32'hFFFF8001, 1'b0};
      vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_4000, 32'h0,        32'h8001F00D, 0,   3,   4, 4'b0011, 32'h0000_4000, 32'h0,        32'h0000F00D, 1'b0};
      vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h000000A5, 32'h0,        0,   1,   2, 4'b0010, 32'h0000_5000, 32'hA5A5A5A5, 32'h0,        1'b0};
      vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'h0000_5002, 32'h0,        32'h00127F00, 0,   0,   1, 4'b0100, 32'h0000_5000, 32'h0,        32'h00000012, 1'b0};
      vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_6004, 32'h0,        32'h11223344, 0,   0,   1, 4'b1111, 32'h0000_6004, 32'h0,        32'h11223344, 1'b0};
      vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0,        32'h55AA55AA, 2,   200, 8, 4'b1111, 32'h0000_7000, 32'h0,        32'h0,        1'b1};
      vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h0000_9000, 32'hCAFEF00D, 32'h12345678, 1,   0,   2, 4'b1111, 32'h0000_9000, 32'hCAFEF00D, 32'h0,        1'b0};

      resetn       = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_sign     = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      dbus_addr_ok = 1'b0;
      dbus_data_ok = 1'b0;
      dbus_rdata   = 32'h0;

      @(negedge clk);
      chk("rst dbus_req", {31'h0, dbus_req}, 32'h0);
      chk("rst dbus_wr", {31'h0, dbus_wr}, 32'h0);
      chk("rst wstrb", {28'h0, dbus_wstrb}, 32'h0);
      chk("rst dbus_addr", dbus_addr, 32'h0);
      chk("rst dbus_wdata", dbus_wdata, 32'h0);
      chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst bus_err", {31'h0, bus_err}, 32'h0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst stallreq", {31'h0, stallreq}, 32'h0);
      resetn = 1'b1;

      for (int i = 0; i < 12; i++)
         run_vec(i, vecs[i]);

      // A data_ok arriving in IDLE (after a timeout) must not produce a response.
      @(negedge clk);
      dbus_data_ok = 1'b1;
      dbus_addr_ok = 1'b1;
      @(negedge clk);
      chk("late data_ok resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("late data_ok dbus_req", {31'h0, dbus_req}, 32'h0);
      chk("late data_ok stallreq", {31'h0, stallreq}, 32'h0);
      dbus_data_ok = 1'b0;
      dbus_addr_ok = 1'b0;

`ifdef MEM_ACCESS_ALIGN_CHK_EN
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'b10;
      req_addr  = 32'h0000_1002;
      #1;
      chk("misalign word", {31'h0, misalign}, 32'h1);
      chk("misalign stall", {31'h0, stallreq}, 32'h0);
      req_size = 2'b01;
      req_addr = 32'h0000_1003;
      #1;
      chk("misalign half odd", {31'h0, misalign}, 32'h1);
      req_size = 2'b10;
      req_addr = 32'h0000_1002;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("misalign no req c%0d", k), {31'h0, dbus_req}, 32'h0);
         chk($sformatf("misalign no stall c%0d", k), {31'h0, stallreq}, 32'h0);
      end
      req_valid = 1'b0;
`else
      // Unchecked build: a misaligned word/half is forced onto its natural lanes.
      v = '{1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0, 32'hABCD1234, 0, 0, 1, 4'b1111, 32'h0000_1000, 32'h0, 32'hABCD1234, 1'b0};
      run_vec(20, v);
      v = '{1'b0, 2'b01, 1'b0, 32'h0000_7003, 32'h0, 32'hBEEF0000, 0, 0, 1, 4'b1100, 32'h0000_7000, 32'h0, 32'h0000BEEF, 1'b0};
      run_vec(21, v);
`endif

      // Reset asserted while in DATA abandons the access at once.
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_size   = 2'b10;
      req_addr   = 32'h0000_8000;
      dbus_rdata = 32'h0;
      @(negedge clk);
      chk("rstmid addr phase req", {31'h0, dbus_req}, 32'h1);
      dbus_addr_ok = 1'b1;
      @(negedge clk);
      chk("rstmid data phase req", {31'h0, dbus_req}, 32'h0);
      chk("rstmid data phase stall", {31'h0, stallreq}, 32'h1);
      dbus_addr_ok = 1'b0;
      #2;
      resetn    = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("rstmid dbus_req", {31'h0, dbus_req}, 32'h0);
      chk("rstmid stallreq", {31'h0, stallreq}, 32'h0);
      chk("rstmid resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rstmid dbus_addr", dbus_addr, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      run_vec(30, vecs[0]);
      run_vec(31, vecs[3]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences load and store accesses issued by the EX/MEM stages onto a split-handshake data bus with variable latency. It builds byte strobes and replicated write data, and holds the pipeline through a stall request until the bus responds. It returns aligned, sign- or zero-extended load data to the MEM stage. It sits between the pipeline's memory stages and the data SRAM/bus bridge, and feeds the central stall controller.

## Interface

Parameters:
- WAIT_MAX, 255 — bus-wait watchdog limit, in cycles (1..65535).

Ports:
- clk  in  1  — clock
- resetn  in  1  — asynchronous, active-low reset
- req_valid  in  1  — EX stage holds a memory instruction this cycle
- req_we  in  1  — 1 = store, 0 = load
- req_size  in  2  — 00 = byte, 01 = half, 10 = word, 11 = treated as word
- req_sign  in  1  — sign-extend the load result
- req_addr  in  32  — byte address
- req_wdata  in  32  — store data, right-justified
- stallreq  out  1  — request pipeline stall
- misalign  out  1  — combinational address-alignment fault for the current request
- dbus_req  out  1  — bus request
- dbus_wr  out  1  — bus write
- dbus_wstrb  out  4  — byte strobes
- dbus_addr  out  32  — bus address
- dbus_wdata  out  32  — bus write data
- dbus_addr_ok  in  1  — address phase accepted
- dbus_data_ok  in  1  — data or write response returned
- dbus_rdata  in  32  — raw read word
- resp_valid  out  1  — access complete (single-cycle pulse)
- resp_rdata  out  32  — aligned and extended load data; 0 for stores and on error
- bus_err  out  1  — watchdog expired (single-cycle pulse, coincident with resp_valid)

## Operation

- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If req_valid is high and there is no misalign, latch we, size, sign, addr[1:0], strobes and data; go to ADDR.
  - If misalign is high, no bus access and no stall; stay in IDLE.
- ADDR:
  - dbus_req = 1.
  - dbus_addr = req address with bits [1:0] cleared.
  - On dbus_addr_ok, go to DATA.
  - If dbus_addr_ok and dbus_data_ok are high in the same cycle, go directly to DONE.
- DATA:
  - dbus_req = 0.
  - On dbus_data_ok, capture the result and go to DONE.
- DONE:
  - resp_valid = 1 for exactly one cycle, then go to IDLE.
  - req_valid is ignored in DONE.
- Strobes:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Write data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged
- Load alignment:
  - byte = dbus_rdata[8*addr[1:0] +: 8]
  - half = dbus_rdata[16*addr[1] +: 16]
  - The selected field is extended to 32 bits, by sign when req_sign = 1, by zeros otherwise.
- Watchdog:
  - A 16-bit counter clears on entry to ADDR and increments each cycle spent in ADDR or DATA.
  - When it reaches WAIT_MAX-1 with no completion, go to DONE with bus_err = 1 and resp_rdata = 0.
  - dbus_data_ok arriving later is ignored.
- stallreq is combinational:
  - 1 when (IDLE & req_valid & ~misalign), or in ADDR, or in DATA.
  - 0 in DONE, so the held instruction advances on the DONE edge.

## Timing

- Reset values: state IDLE; dbus_req, dbus_wr, dbus_wstrb, resp_valid, bus_err = 0; dbus_addr, dbus_wdata, resp_rdata = 0.
- resetn asserted mid-access aborts immediately; any outstanding bus transaction is abandoned.
- Minimum latency, with addr_ok and data_ok both in the first ADDR cycle:
  - req_valid is sampled at edge 0.
  - dbus_req is high in cycle 1.
  - DONE (resp_valid) is in cycle 2.
  - stallreq is high in cycles 0–1.
- dbus_req and the address/strobe/data fields are held stable throughout ADDR.
- resp_rdata is registered and valid only while resp_valid is high.

## Configuration

- MEM_ACCESS_ALIGN_CHK_EN defined: misalign = req_valid & ((half & addr[0]) | (word & addr[1:0] != 0)). Misaligned requests are dropped as described in Operation.
- MEM_ACCESS_ALIGN_CHK_EN undefined: misalign is tied to 0. Half accesses force addr[0] = 0 and word accesses force addr[1:0] = 0 for strobe and data selection.

## Test plan

- Word load at 0x1000; addr_ok and data_ok both in cycle 1 with rdata 0xDEADBEEF -> resp_valid in cycle 2, resp_rdata = 0xDEADBEEF, stallreq high for 2 cycles.
- Signed byte load at 0x1003 with rdata 0x80FF_FFFF -> resp_rdata = 0xFFFFFF80; the same access unsigned -> 0x00000080.
- Half store of 0x1234ABCD at 0x2002 -> dbus_wr = 1, wstrb = 4'b1100, wdata = 0xABCDABCD, dbus_addr = 0x2000; addr_ok delayed 3 cycles and data_ok 2 cycles later -> stallreq holds throughout, resp_rdata = 0.
- Word load at 0x1002 with MEM_ACCESS_ALIGN_CHK_EN defined -> misalign = 1, dbus_req never asserted, stallreq = 0.
- WAIT_MAX = 8 and data_ok never returned -> bus_err and resp_valid pulse together exactly 8 cycles after entering ADDR; resp_rdata = 0.
- resetn pulsed low while in DATA -> dbus_req = 0, stallreq = 0 and state IDLE immediately; the next request proceeds normally.
